// File: rtl/bp_be_pkg.sv
// Shared backend types for the dual-issue integer scheduler: dispatch packet,
// integer FU opcodes and scheduler states.
package bp_be_pkg;

  localparam int vaddr_width_gp = 39;
  localparam int dpath_width_gp = 64;

  typedef enum logic [3:0] {
    e_int_add = 4'd0,
    e_int_sub = 4'd1,
    e_int_xor = 4'd2
  } bp_be_int_fu_op_e;

  // The v field doubles as the pipe's valid, so an all-zero packet is a bubble.
  typedef struct packed {
    logic                      v;
    logic [vaddr_width_gp-1:0] pc;
    bp_be_int_fu_op_e          fu_op;
    logic [dpath_width_gp-1:0] rs1;
    logic [dpath_width_gp-1:0] rs2;
  } bp_be_dispatch_pkt_s;

  localparam int dispatch_pkt_width_gp = $bits(bp_be_dispatch_pkt_s);

  typedef enum logic {
    e_idle,
    e_hold
  } bp_be_int_sched_state_e;

endpackage

// File: rtl/bp_be_int_sched_cnt.sv
// Saturating up-counter of dual-int conflicts; only reset clears it.
module bp_be_int_sched_cnt #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i)
      count_o <= '0;
    else if (up_i && (count_o != {width_p{1'b1}}))
      count_o <= count_o + 1'b1;
  end

endmodule

// File: rtl/bp_be_int_dual_sched.sv
// Shares the single integer pipe between both dispatch slots; on a conflict the
// younger slot is parked for one cycle and dispatch is stalled.
module bp_be_int_dual_sched
  import bp_be_pkg::*;
#(
  parameter  int cnt_width_p           = 16,
  localparam int dispatch_pkt_width_lp = dispatch_pkt_width_gp
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [dispatch_pkt_width_lp-1:0] slot0_pkt_i,
  input  logic                             slot0_v_i,
  input  logic [dispatch_pkt_width_lp-1:0] slot1_pkt_i,
  input  logic                             slot1_v_i,
  output logic                             ready_o,
  input  logic                             flush_i,
  output logic [dispatch_pkt_width_lp-1:0] pipe_pkt_o,
  input  logic [dpath_width_gp-1:0]        pipe_data_i,
  input  logic                             pipe_v_i,
  output logic [dpath_width_gp-1:0]        slot0_data_o,
  output logic                             slot0_v_o,
  output logic [dpath_width_gp-1:0]        slot1_data_o,
  output logic                             slot1_v_o,
  output logic [cnt_width_p-1:0]           conflict_cnt_o
);

  bp_be_int_sched_state_e state_r, state_n;
  logic [dispatch_pkt_width_lp-1:0] hold_r;
  logic issue0, issue1, capture;

  // Flush squashes issue in both states; a flushed hold simply falls back to idle.
  always_comb begin
    state_n    = state_r;
    pipe_pkt_o = '0;
    issue0     = 1'b0;
    issue1     = 1'b0;
    capture    = 1'b0;
    if (reset_n_i) begin
      case (state_r)
        e_idle: begin
          if (!flush_i) begin
            if (slot0_v_i) begin
              pipe_pkt_o = slot0_pkt_i;
              issue0     = 1'b1;
              if (slot1_v_i) begin
                capture = 1'b1;
                state_n = e_hold;
              end
            end else if (slot1_v_i) begin
              pipe_pkt_o = slot1_pkt_i;
              issue1     = 1'b1;
            end
          end
        end
        e_hold: begin
          state_n = e_idle;
          if (!flush_i) begin
            pipe_pkt_o = hold_r;
            issue1     = 1'b1;
          end
        end
        default: state_n = e_idle;
      endcase
    end
  end

  assign ready_o = reset_n_i & (state_r == e_idle);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= e_idle;
      hold_r  <= '0;
    end else begin
      state_r <= state_n;
      if (capture)
        hold_r <= slot1_pkt_i;
    end
  end

  // Issue flags are already flush-gated, so only the pipe valid is needed here.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      slot0_v_o    <= 1'b0;
      slot1_v_o    <= 1'b0;
      slot0_data_o <= '0;
      slot1_data_o <= '0;
    end else begin
      slot0_v_o <= issue0 & pipe_v_i;
      slot1_v_o <= issue1 & pipe_v_i;
      if (issue0 && pipe_v_i)
        slot0_data_o <= pipe_data_i;
      if (issue1 && pipe_v_i)
        slot1_data_o <= pipe_data_i;
    end
  end

  bp_be_int_sched_cnt #(
    .width_p(cnt_width_p)
  ) conflict_cnt (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .up_i     (capture),
    .count_o  (conflict_cnt_o)
  );

endmodule

// File: tb/tb_bp_be_int_dual_sched.sv
// Self-checking bench: the bench plays the integer pipe and compares the
// scheduler against a per-op reference model under directed and random traffic.
module tb_bp_be_int_dual_sched;
  import bp_be_pkg::*;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                              clk = 1'b0;
  logic                              reset_n_i;
  logic [dispatch_pkt_width_gp-1:0]  slot0_pkt_i, slot1_pkt_i, pipe_pkt_o;
  logic                              slot0_v_i, slot1_v_i, ready_o, flush_i;
  logic [dpath_width_gp-1:0]         pipe_data_i, slot0_data_o, slot1_data_o;
  logic                              pipe_v_i, slot0_v_o, slot1_v_o;
  logic [CNT_W-1:0]                  conflict_cnt_o;
  logic                              drop;

  int total = 0;
  int bad   = 0;

  bit                         m_held;
  bp_be_dispatch_pkt_s        m_held_pkt;
  int                         m_cnt;
  logic                       exp_v0, exp_v1;
  logic [dpath_width_gp-1:0]  exp_d0, exp_d1;
  bp_be_dispatch_pkt_s        zpkt;

  always #5 clk = ~clk;

  bp_be_int_dual_sched #(
    .cnt_width_p(CNT_W)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n_i),
    .slot0_pkt_i   (slot0_pkt_i),
    .slot0_v_i     (slot0_v_i),
    .slot1_pkt_i   (slot1_pkt_i),
    .slot1_v_i     (slot1_v_i),
    .ready_o       (ready_o),
    .flush_i       (flush_i),
    .pipe_pkt_o    (pipe_pkt_o),
    .pipe_data_i   (pipe_data_i),
    .pipe_v_i      (pipe_v_i),
    .slot0_data_o  (slot0_data_o),
    .slot0_v_o     (slot0_v_o),
    .slot1_data_o  (slot1_data_o),
    .slot1_v_o     (slot1_v_o),
    .conflict_cnt_o(conflict_cnt_o)
  );

  function automatic logic [dpath_width_gp-1:0] alu(bp_be_dispatch_pkt_s p);
    case (p.fu_op)
      e_int_add: return p.rs1 + p.rs2;
      e_int_sub: return p.rs1 - p.rs2;
      e_int_xor: return p.rs1 ^ p.rs2;
      default:   return '0;
    endcase
  endfunction

  // Combinational integer pipe stand-in; drop models a pipe that withholds its valid.
  assign pipe_data_i = alu(bp_be_dispatch_pkt_s'(pipe_pkt_o));
  assign pipe_v_i    = pipe_pkt_o[dispatch_pkt_width_gp-1] & ~drop;

  function automatic bp_be_dispatch_pkt_s mkPkt(bp_be_int_fu_op_e op, logic [63:0] a, logic [63:0] b);
    bp_be_dispatch_pkt_s p;
    p.v     = 1'b1;
    p.pc    = {$urandom, $urandom};
    p.fu_op = op;
    p.rs1   = a;
    p.rs2   = b;
    return p;
  endfunction

  function automatic bp_be_dispatch_pkt_s randPkt();
    return mkPkt(bp_be_int_fu_op_e'($urandom_range(0, 2)), {$urandom, $urandom}, {$urandom, $urandom});
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: check last cycle's registered results, drive new inputs,
  // check the combinational issue decision, then advance the reference model.
  task automatic applyStimulus(input logic s0v, input bp_be_dispatch_pkt_s p0,
                               input logic s1v, input bp_be_dispatch_pkt_s p1,
                               input logic fl, input logic dr, input logic rn);
    bp_be_dispatch_pkt_s exp_pipe;
    logic exp_rdy, n_v0, n_v1;
    @(negedge clk);
    checkOutput("slot0_v", slot0_v_o, exp_v0);
    checkOutput("slot0_data", slot0_data_o, exp_d0);
    checkOutput("slot1_v", slot1_v_o, exp_v1);
    checkOutput("slot1_data", slot1_data_o, exp_d1);
    checkOutput("conflict_cnt", conflict_cnt_o, m_cnt);
    slot0_v_i   = s0v;
    slot0_pkt_i = p0;
    slot1_v_i   = s1v;
    slot1_pkt_i = p1;
    flush_i     = fl;
    drop        = dr;
    reset_n_i   = rn;
    #1;
    exp_pipe = '0;
    exp_rdy  = 1'b0;
    n_v0     = 1'b0;
    n_v1     = 1'b0;
    if (!rn) begin
      m_held = 0;
      m_cnt  = 0;
      exp_d0 = '0;
      exp_d1 = '0;
    end else if (m_held) begin
      m_held = 0;
      if (!fl) begin
        exp_pipe = m_held_pkt;
        n_v1     = !dr;
        if (n_v1) exp_d1 = alu(m_held_pkt);
      end
    end else begin
      exp_rdy = 1'b1;
      if (!fl) begin
        if (s0v) begin
          exp_pipe = p0;
          n_v0     = !dr;
          if (n_v0) exp_d0 = alu(p0);
          if (s1v) begin
            m_held     = 1;
            m_held_pkt = p1;
            if (m_cnt < CNT_MAX) m_cnt++;
          end
        end else if (s1v) begin
          exp_pipe = p1;
          n_v1     = !dr;
          if (n_v1) exp_d1 = alu(p1);
        end
      end
    end
    checkOutput("ready", ready_o, exp_rdy);
    checkOutput("pipe_pkt", pipe_pkt_o, exp_pipe);
    exp_v0 = n_v0;
    exp_v1 = n_v1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, zpkt, 1'b0, zpkt, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    zpkt        = '0;
    m_held      = 0;
    m_cnt       = 0;
    exp_v0      = 1'b0;
    exp_v1      = 1'b0;
    exp_d0      = '0;
    exp_d1      = '0;
    reset_n_i   = 1'b0;
    slot0_v_i   = 1'b0;
    slot1_v_i   = 1'b0;
    slot0_pkt_i = '0;
    slot1_pkt_i = '0;
    flush_i     = 1'b0;
    drop        = 1'b0;
    repeat (2) @(posedge clk);
    applyStimulus(1'b1, randPkt(), 1'b1, randPkt(), 1'b0, 1'b0, 1'b0);

    // Single slot 0 ADD
    applyStimulus(1'b1, mkPkt(e_int_add, 5, 7), 1'b0, zpkt, 1'b0, 1'b0, 1'b1);
    idleCycle();
    checkOutput("add_result", slot0_data_o, 12);
    checkOutput("add_ready", ready_o, 1'b1);

    // Conflict pair ADD/SUB
    applyStimulus(1'b1, mkPkt(e_int_add, 5, 7), 1'b1, mkPkt(e_int_sub, 9, 4), 1'b0, 1'b0, 1'b1);
    idleCycle();
    checkOutput("conf_s0", slot0_data_o, 12);
    checkOutput("conf_cnt", conflict_cnt_o, 1);
    idleCycle();
    checkOutput("conf_s1", slot1_data_o, 5);
    checkOutput("conf_s1_v", slot1_v_o, 1'b1);
    checkOutput("conf_ready", ready_o, 1'b1);

    // Flush in hold: younger op never returns
    applyStimulus(1'b1, mkPkt(e_int_add, 1, 2), 1'b1, mkPkt(e_int_sub, 9, 4), 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, zpkt, 1'b0, zpkt, 1'b1, 1'b0, 1'b1);
    checkOutput("flush_s0", slot0_data_o, 3);
    idleCycle();
    checkOutput("flush_s1_v", slot1_v_o, 1'b0);
    checkOutput("flush_ready", ready_o, 1'b1);

    // Slot 1 only XOR
    applyStimulus(1'b0, zpkt, 1'b1, mkPkt(e_int_xor, 64'hF0, 64'h0F), 1'b0, 1'b0, 1'b1);
    idleCycle();
    checkOutput("xor_result", slot1_data_o, 64'hFF);
    checkOutput("xor_s0_v", slot0_v_o, 1'b0);

    // Reset while holding
    applyStimulus(1'b1, randPkt(), 1'b1, randPkt(), 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, zpkt, 1'b0, zpkt, 1'b0, 1'b0, 1'b0);
    idleCycle();
    checkOutput("rst_cnt", conflict_cnt_o, 0);
    checkOutput("rst_s1_v", slot1_v_o, 1'b0);

    // Counter saturation
    for (int i = 0; i < CNT_MAX + 5; i++) begin
      applyStimulus(1'b1, randPkt(), 1'b1, randPkt(), 1'b0, 1'b0, 1'b1);
      idleCycle();
    end
    checkOutput("sat_cnt", conflict_cnt_o, CNT_MAX);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 1), randPkt(), $urandom_range(0, 1), randPkt(),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 99) != 0));
    end
    idleCycle();
    idleCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bp_be_int_dual_sched.md
Name: bp_be_int_dual_sched

Overview:
- Issue scheduler that shares the single combinational integer pipe (bp_be_pipe_int) between the two dispatch slots of the dual-issue backend.
- Sits between dual dispatch and the integer pipe.
- When both slots carry integer ops in one cycle, it issues slot 0 (older) first and parks slot 1 in a holding register for the next cycle, stalling dispatch for that cycle.
- Results return per slot, registered, with the slot identity preserved.

Parameters:
- bp_params_p, e_bp_default_cfg, processor configuration; supplies vaddr_width_p and related widths.
- dispatch_pkt_width_lp (localparam), `bp_be_dispatch_pkt_width(vaddr_width_p), width of one dispatch packet.
- cnt_width_p, 16, width of the saturating conflict counter.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  synchronous, active-low reset
- slot0_pkt_i  in  dispatch_pkt_width_lp  older-slot dispatch packet
- slot0_v_i  in  1  slot 0 carries an integer-pipe op
- slot1_pkt_i  in  dispatch_pkt_width_lp  younger-slot dispatch packet
- slot1_v_i  in  1  slot 1 carries an integer-pipe op
- ready_o  out  1  scheduler accepts the presented slot pair this cycle
- flush_i  in  1  squash everything not yet returned
- pipe_pkt_o  out  dispatch_pkt_width_lp  reservation driven to the shared integer pipe
- pipe_data_i  in  dpath_width_gp  pipe result (same cycle)
- pipe_v_i  in  1  pipe result valid
- slot0_data_o  out  dpath_width_gp  registered slot 0 result
- slot0_v_o  out  1  slot 0 result valid
- slot1_data_o  out  dpath_width_gp  registered slot 1 result
- slot1_v_o  out  1  slot 1 result valid
- conflict_cnt_o  out  cnt_width_p  number of dual-int conflicts since reset

Behaviour:
- Reset (reset_n_i=0 at posedge):
  - state=e_idle; hold register cleared.
  - All *_v_o=0, all *_data_o=0, conflict_cnt_o=0.
  - ready_o=0 while reset_n_i is low.
- ready_o = reset_n_i & (state==e_idle). It is purely state-based and never depends on slot valids.
- pipe_pkt_o is all-zero whenever nothing is issued, so the pipe's v is 0.
- State e_idle (input pair is consumed this cycle):
  - Slot 0 only valid: pipe_pkt_o=slot0_pkt_i; stay e_idle.
  - Slot 1 only valid: pipe_pkt_o=slot1_pkt_i; stay e_idle.
  - Both valid: pipe_pkt_o=slot0_pkt_i; capture slot1_pkt_i in the hold register; go to e_hold; increment conflict_cnt_o.
- State e_hold:
  - pipe_pkt_o=hold register; inputs ignored; next state e_idle.
- Result capture:
  - The op issued in cycle t has its result registered at posedge t+1.
  - slotN_v_o(t+1) = issued_for_slotN(t) & pipe_v_i(t) & ~flush_i(t).
  - slotN_data_o takes pipe_data_i(t) whenever slotN_v_o is set.
  - Valids are single-cycle pulses; data holds when valid is 0.
  - At most one of slot0_v_o/slot1_v_o is high in any cycle.
- Latency: 1 cycle for an unpaired op. For a conflicting pair, slot 0 returns at t+1 and slot 1 at t+2. Slot 1 never returns before slot 0 of the same pair.
- flush_i:
  - In e_idle: no issue (pipe_pkt_o=0), no hold capture, no counter increment; stay e_idle.
  - In e_hold: drop the held packet, pipe_pkt_o=0, go to e_idle.
  - Any result that would be registered in the flush cycle is suppressed.
  - Results already visible on *_v_o in the flush cycle are unaffected.
- conflict_cnt_o saturates at all-ones and is cleared only by reset.
- Reset asserted in e_hold: the held op is discarded and no result is produced.

Decomposition:
- bp_be_pkg gets bp_be_int_sched_state_e {e_idle, e_hold}. Dispatch packet struct and widths come from the existing internal-if macros.
- Natural sub-module: bsg_counter_clear_up-style saturating counter, named bp_be_int_sched_cnt. Everything else lives inline.
- The shared bp_be_pipe_int is instantiated by the parent, not inside this block.

Test Plan:
- Single op: slot0 ADD rs1=5 rs2=7, slot1 invalid -> pipe_pkt_o=slot0 pkt same cycle; next cycle slot0_v_o=1, slot0_data_o=12; ready_o stays 1.
- Conflict: slot0 ADD 5+7, slot1 SUB 9-4 in the same cycle -> ready_o drops to 0 the next cycle; slot0_data_o=12 at t+1, slot1_data_o=5 at t+2; conflict_cnt_o=1; ready_o=1 at t+2.
- Flush in hold: the conflict above with flush_i=1 in the e_hold cycle -> slot0 result still appears at t+1; slot1_v_o never asserts; state e_idle; ready_o=1 next cycle.
- Slot1-only op: slot1 XOR 0xF0^0x0F -> slot1_v_o=1, slot1_data_o=0xFF after 1 cycle; slot0_v_o stays 0.
- Reset mid-hold: reset_n_i=0 during e_hold -> no results, conflict_cnt_o=0, ready_o=0 during reset, 1 afterwards.
- Saturation: force 65536 conflicts -> conflict_cnt_o holds at 0xFFFF.
